// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding and coin value constants for the vending controller
//   state_t      : IDLE / COLLECT / VEND / CHANGE
//   COIN_*       : face value of each detector pulse
//   MAX_COIN_SUM : largest credit one cycle of simultaneous pulses can add
package vending_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;
    localparam int COIN_1       = 1;
    localparam int COIN_2       = 2;
    localparam int COIN_5       = 5;
    localparam int MAX_COIN_SUM = 8;
endpackage

// File: rtl/vending_coin_sum.sv
// vending_coin_sum: combinational adder turning coin detector pulses into a credit value
//   i_1yuan, i_2yuan, i_5yuan : single-cycle coin pulses
//   o_sum                     : CRD_W-bit total value of the pulses present this cycle
module vending_coin_sum
    import vending_pkg::*;
#(
    parameter int CRD_W = 4
) (
    input  logic             i_1yuan,
    input  logic             i_2yuan,
    input  logic             i_5yuan,
    output logic [CRD_W-1:0] o_sum
);
    always_comb begin
        o_sum = (i_1yuan ? CRD_W'(COIN_1) : '0)
              + (i_2yuan ? CRD_W'(COIN_2) : '0)
              + (i_5yuan ? CRD_W'(COIN_5) : '0);
    end
endmodule

// File: rtl/vending_change_fsm.sv
// vending_change_fsm: coin-operated vending controller with cancel/refund and valid/ready change port
//   i_clk, i_rst                : clock and synchronous active-high reset
//   i_1yuan, i_2yuan, i_5yuan   : coin detector pulses
//   i_cancel                    : refund request pulse
//   i_chg_ready                 : hopper takes the offered change coin this cycle
//   o_chg_valid, o_chg_coin     : change coin offered (coin 1 = 2 yuan, 0 = 1 yuan)
//   o_done                      : one-cycle vend pulse per sale
//   o_coin_reject               : one-cycle pulse for a coin returned while busy
//   o_credit                    : credit, or outstanding change while paying out
module vending_change_fsm
    import vending_pkg::*;
#(
    parameter int PRICE = 6,
    parameter int CRD_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_1yuan,
    input  logic             i_2yuan,
    input  logic             i_5yuan,
    input  logic             i_cancel,
    input  logic             i_chg_ready,
    output logic             o_chg_valid,
    output logic             o_chg_coin,
    output logic             o_done,
    output logic             o_coin_reject,
    output logic [CRD_W-1:0] o_credit
);
    localparam logic [CRD_W-1:0] PRICE_C = CRD_W'(PRICE);
    localparam logic [CRD_W-1:0] ONE_C   = CRD_W'(1);
    localparam logic [CRD_W-1:0] TWO_C   = CRD_W'(2);

    state_t           state_q, state_d;
    logic [CRD_W-1:0] credit_q, credit_d;
    logic [CRD_W-1:0] remain_q, remain_d;
    logic             done_q, done_d;
    logic             reject_q, reject_d;
    logic [CRD_W-1:0] coin_in;
    logic [CRD_W-1:0] sum;
    logic [CRD_W-1:0] remain_dec;
    logic             any_coin;

    vending_coin_sum #(.CRD_W(CRD_W)) u_coin_sum (
        .i_1yuan (i_1yuan),
        .i_2yuan (i_2yuan),
        .i_5yuan (i_5yuan),
        .o_sum   (coin_in)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        // credit stays below PRICE while collecting, so the sum fits in CRD_W bits
        sum        = credit_q + coin_in;
        any_coin   = i_1yuan | i_2yuan | i_5yuan;
        remain_dec = remain_q - ((remain_q >= TWO_C) ? TWO_C : ONE_C);
        state_d    = state_q;
        credit_d   = credit_q;
        remain_d   = remain_q;
        reject_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_in != '0) begin
                    credit_d = coin_in;
                    state_d  = (coin_in >= PRICE_C) ? VEND : COLLECT;
                    remain_d = (coin_in >= PRICE_C) ? coin_in - PRICE_C : '0;
                end
            end
            COLLECT: begin
                // a sale reached in the same cycle as a cancel takes precedence
                if (sum >= PRICE_C) begin
                    state_d  = VEND;
                    credit_d = sum;
                    remain_d = sum - PRICE_C;
                end else if (i_cancel) begin
                    state_d  = CHANGE;
                    credit_d = '0;
                    remain_d = sum;
                end else begin
                    credit_d = sum;
                end
            end
            VEND: begin
                credit_d = '0;
                state_d  = (remain_q != '0) ? CHANGE : IDLE;
                reject_d = any_coin;
            end
            CHANGE: begin
                reject_d = any_coin;
                if (i_chg_ready) begin
                    remain_d = remain_dec;
                    state_d  = (remain_dec == '0) ? IDLE : CHANGE;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == VEND);
    end

    always_comb begin
        o_done        = done_q;
        o_coin_reject = reject_q;
        o_chg_valid   = (state_q == CHANGE);
        o_chg_coin    = (state_q == CHANGE) && (remain_q >= TWO_C);
        o_credit      = (state_q == CHANGE) ? remain_q : credit_q;
    end
endmodule
